io_input_controller: RTL and testbench

Input-port controller for the unicycle MIPS datapath. It services the IN instruction by stalling the processor until the user confirms a switch value with a debounced button press. It then presents the captured value on `data_IO`, which the register write-back data selector consumes. The block also owns switch/button synchronisation and button debouncing.

---
 rtl/io_input_controller_pkg.sv | 16 +
 rtl/io_input_controller_if.sv | 30 +++
 rtl/io_input_controller_debouncer.sv | 39 +++
 rtl/io_input_controller.sv | 108 ++++++++++
 tb/tb_io_input_controller.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/io_input_controller_pkg.sv
// Purpose : shared types and constants for the IN-instruction input controller.
// Latency : n/a (declarations only).
// Backpressure: n/a.
// Contents: io_state_t (request FSM states), DATA_W (datapath word width).
package io_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ARM        = 2'd1,
    WAIT_PRESS = 2'd2,
    DONE       = 2'd3
  } io_state_t;

endpackage

// File: rtl/io_input_controller_if.sv
// Purpose : groups the processor/board-facing signals of the input controller.
// Latency : n/a (wiring only).
// Backpressure: io_stall holds the processor until io_ready strobes.
// Signals : io_read (IN decoded), switches/button (raw board inputs),
//           io_stall, io_ready (1-cycle strobe), data_IO (extended capture).
interface io_input_controller_if #(
  parameter int SW_WIDTH = 16
);
  import io_pkg::*;

  logic                io_read;
  logic [SW_WIDTH-1:0] switches;
  logic                button;
  logic                io_stall;
  logic                io_ready;
  logic [DATA_W-1:0]   data_IO;

  // master: the datapath/board side that issues IN and supplies raw inputs
  modport master (
    output io_read, switches, button,
    input  io_stall, io_ready, data_IO
  );

  // slave: the input controller itself
  modport slave (
    input  io_read, switches, button,
    output io_stall, io_ready, data_IO
  );

endinterface

// File: rtl/io_input_controller_debouncer.sv
// Purpose : debounces the synchronised confirm button into a clean level.
// Latency : clean level follows btn_sync after DEBOUNCE_CYCLES stable cycles.
// Backpressure: none; free-running filter.
// Ports   : clock, reset (sync, active-high), btn_sync (synchronised raw
//           button), btn_clean (filtered level).
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_sync,
  output logic btn_clean
);

  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_clean;

  // The counter measures how long btn_sync has disagreed with the clean
  // level; any agreement restarts the measurement, so short glitches vanish.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt   <= '0;
      r_clean <= 1'b0;
    end else if (btn_sync == r_clean) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_clean <= btn_sync;
      r_cnt   <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign btn_clean = r_clean;

endmodule

// File: rtl/io_input_controller.sv
// Purpose : services IN by stalling until a debounced button press captures the switches.
// Latency : min 4 cycles per IN (IDLE, ARM, WAIT_PRESS, DONE); stall is combinational.
// Backpressure: io_stall held while io_read is high and no capture has completed.
// Ports   : clock, reset (sync, active-high), bus (slave modport: io_read,
//           switches, button in; io_stall, io_ready, data_IO out).
module io_input_controller
  import io_pkg::*;
#(
  parameter int SW_WIDTH        = 16,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SIGN_EXTEND     = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  io_input_controller_if.slave  bus
);

  logic                r_btn_meta;
  logic                r_btn_sync;
  logic [SW_WIDTH-1:0] r_sw_meta;
  logic [SW_WIDTH-1:0] r_sw_sync;
  logic                w_btn_clean;
  io_state_t           r_state;
  io_state_t           w_state_next;
  logic                w_capture;
  logic [SW_WIDTH-1:0] r_data;

  // Two-flop synchronisers for the asynchronous board inputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_btn_meta <= 1'b0;
      r_btn_sync <= 1'b0;
      r_sw_meta  <= '0;
      r_sw_sync  <= '0;
    end else begin
      r_btn_meta <= bus.button;
      r_btn_sync <= r_btn_meta;
      r_sw_meta  <= bus.switches;
      r_sw_sync  <= r_sw_meta;
    end
  end

  button_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clock     (clock),
    .reset     (reset),
    .btn_sync  (r_btn_sync),
    .btn_clean (w_btn_clean)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ARM insists on seeing the button released before WAIT_PRESS accepts a
  // press, so a held button (or the press that finished the previous IN)
  // can never satisfy a new request.
  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.io_read) w_state_next = ARM;
      end
      ARM: begin
        if (!bus.io_read)     w_state_next = IDLE;
        else if (!w_btn_clean) w_state_next = WAIT_PRESS;
      end
      WAIT_PRESS: begin
        if (!bus.io_read) begin
          w_state_next = IDLE;
        end else if (w_btn_clean) begin
          w_state_next = DONE;
          w_capture    = 1'b1;
        end
      end
      DONE: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_data <= '0;
    end else if (w_capture) begin
      r_data <= r_sw_sync;
    end
  end

  // Stall drops in DONE so the PC advances on the same edge as write-back.
  assign bus.io_stall = bus.io_read & (r_state != DONE) & ~reset;
  assign bus.io_ready = (r_state == DONE);

  // Replicate the MSB across the full word and keep the low DATA_W bits.
  assign bus.data_IO = (SIGN_EXTEND != 0)
                     ? DATA_W'({{DATA_W{r_data[SW_WIDTH-1]}}, r_data})
                     : DATA_W'(r_data);

endmodule

// File: tb/tb_io_input_controller.sv
module tb_io_input_controller;
  import io_pkg::*;

  localparam int SW = 16;
  localparam int DB = 4;

  logic          clock    = 1'b0;
  logic          reset    = 1'b1;
  logic          io_read  = 1'b0;
  logic          button   = 1'b0;
  logic [SW-1:0] switches = '0;

  always #5 clock = ~clock;

  io_input_controller_if #(.SW_WIDTH(SW)) bus0 ();
  io_input_controller_if #(.SW_WIDTH(SW)) bus1 ();

  assign bus0.io_read  = io_read;
  assign bus0.button   = button;
  assign bus0.switches = switches;
  assign bus1.io_read  = io_read;
  assign bus1.button   = button;
  assign bus1.switches = switches;

  io_input_controller #(.SW_WIDTH(SW), .DEBOUNCE_CYCLES(DB), .SIGN_EXTEND(0)) dut0 (
    .clock (clock), .reset (reset), .bus (bus0));
  io_input_controller #(.SW_WIDTH(SW), .DEBOUNCE_CYCLES(DB), .SIGN_EXTEND(1)) dut1 (
    .clock (clock), .reset (reset), .bus (bus1));

  int tests     = 0;
  int fails     = 0;
  int ready_cnt = 0;
  bit chk_en    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // Raw inputs reach the logic two edges late; the clean button level flips
  // once the last DB synchronised samples all disagree with it. A request
  // is accepted, must then observe a released button, then a press.
  bit          m_bs1, m_bs2;
  logic [SW-1:0] m_ss1, m_ss2;
  bit          m_clean;
  bit          hist[$];
  bit          m_req, m_rel, m_done, m_all;
  logic [SW-1:0] m_data;

  function automatic logic [31:0] ext(input logic [SW-1:0] d, input bit s);
    return s ? {{(32-SW){d[SW-1]}}, d} : {{(32-SW){1'b0}}, d};
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      m_bs1 = 0; m_bs2 = 0; m_ss1 = '0; m_ss2 = '0;
      m_clean = 0; hist.delete();
      m_req = 0; m_rel = 0; m_done = 0; m_data = '0;
    end else begin
      if (m_done) begin
        m_done = 0; m_req = 0; m_rel = 0;
      end else if (!io_read) begin
        m_req = 0; m_rel = 0;
      end else if (!m_req) begin
        m_req = 1;
      end else if (!m_rel) begin
        if (!m_clean) m_rel = 1;
      end else if (m_clean) begin
        m_data = m_ss2; m_done = 1; m_req = 0; m_rel = 0;
      end
      hist.push_back(m_bs2);
      if (hist.size() > DB) void'(hist.pop_front());
      if (hist.size() == DB) begin
        m_all = 1;
        foreach (hist[i]) if (hist[i] == m_clean) m_all = 0;
        if (m_all) m_clean = ~m_clean;
      end
      m_bs2 = m_bs1; m_bs1 = button;
      m_ss2 = m_ss1; m_ss1 = switches;
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      check("stall0", bus0.io_stall, (io_read && !m_done && !reset));
      check("stall1", bus1.io_stall, (io_read && !m_done && !reset));
      check("ready0", bus0.io_ready, m_done);
      check("ready1", bus1.io_ready, m_done);
      check("data0",  bus0.data_IO, ext(m_data, 0));
      check("data1",  bus1.data_IO, ext(m_data, 1));
    end
    if (bus0.io_ready === 1'b1) ready_cnt++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic wait_ready(input string name, input int bound, output int n);
    n = 0;
    for (int i = 1; i <= bound; i++) begin
      @(posedge clock);
      @(negedge clock);
      if (bus0.io_ready === 1'b1) begin
        n = i;
        break;
      end
    end
    if (n == 0) begin
      tests++;
      fails++;
      $display("FAIL %s: io_ready not seen, waited %0d cycles", name, bound);
    end
  endtask

  task automatic run_in(input string name, input logic [SW-1:0] sw,
                        input logic [31:0] exp0, input logic [31:0] exp1);
    int n;
    int c0;
    c0       = ready_cnt;
    switches = sw;
    io_read  = 1'b1;
    @(negedge clock);
    check({name, "_stall_first"}, bus0.io_stall, 1);
    @(posedge clock); #1;
    button = 1'b1;
    wait_ready(name, 40, n);
    check({name, "_data0"}, bus0.data_IO, exp0);
    check({name, "_data1"}, bus1.data_IO, exp1);
    @(posedge clock); #1;
    io_read = 1'b0;
    button  = 1'b0;
    tick(12);
    check({name, "_one_ready"}, ready_cnt - c0, 1);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int n;
    int c0;

    reset = 1'b1;
    tick(1);
    chk_en = 1;
    @(negedge clock);
    check("rst_stall", bus0.io_stall, 0);
    check("rst_ready", bus0.io_ready, 0);
    check("rst_data",  bus0.data_IO, 0);
    @(posedge clock); #1;
    reset = 1'b0;
    tick(5);

    // basic read and extension variants
    run_in("basic", 16'h00A5, 32'h000000A5, 32'h000000A5);
    run_in("sext",  16'h8001, 32'h00008001, 32'hFFFF8001);

    // bounce rejection: 2-cycle glitches, then a held press
    switches = 16'h1234;
    io_read  = 1'b1;
    c0       = ready_cnt;
    tick(4);
    for (int i = 0; i < 5; i++) begin
      button = 1'b1; tick(2);
      button = 1'b0; tick(2);
    end
    button = 1'b1;
    wait_ready("bounce", 30, n);
    check("bounce_latency", n, 7);
    check("bounce_data", bus0.data_IO, 32'h00001234);
    @(posedge clock); #1;
    io_read = 1'b0;
    button  = 1'b0;
    tick(12);
    check("bounce_one_ready", ready_cnt - c0, 1);

    // held button, then back-to-back IN with a single press
    button = 1'b1;
    tick(12);
    switches = 16'hBEEF;
    io_read  = 1'b1;
    c0       = ready_cnt;
    tick(15);
    @(negedge clock);
    check("held_no_ready", ready_cnt - c0, 0);
    check("held_stall", bus0.io_stall, 1);
    @(posedge clock); #1;
    button = 1'b0;
    tick(10);
    button = 1'b1;
    wait_ready("held", 30, n);
    check("held_data1", bus1.data_IO, 32'hFFFFBEEF);
    tick(20);
    check("b2b_one_ready", ready_cnt - c0, 1);
    io_read = 1'b0;
    button  = 1'b0;
    tick(12);

    // reset while waiting for a press
    switches = 16'h5A5A;
    io_read  = 1'b1;
    tick(4);
    reset = 1'b1;
    @(negedge clock);
    check("midrst_stall", bus0.io_stall, 0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check("midrst_data", bus0.data_IO, 0);
    @(posedge clock); #1;
    tick(2);
    button = 1'b1;
    wait_ready("midrst", 30, n);
    check("midrst_capture", bus0.data_IO, 32'h00005A5A);
    @(posedge clock); #1;
    io_read = 1'b0;
    button  = 1'b0;
    tick(12);

    // abort in WAIT_PRESS
    switches = 16'h0F0F;
    io_read  = 1'b1;
    tick(4);
    io_read = 1'b0;
    c0      = ready_cnt;
    tick(10);
    check("abort_no_ready", ready_cnt - c0, 0);
    check("abort_data", bus0.data_IO, 32'h00005A5A);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) io_read = ~io_read;
      if ($urandom_range(0, 5) == 0)  button  = ~button;
      switches = SW'($urandom);
      reset    = ($urandom_range(0, 299) == 0);
      tick(1);
    end
    reset   = 1'b0;
    io_read = 1'b0;
    tick(5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
